// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline definitions: ALU opcodes, register bus type, stage
// indices, stall hold vectors and redirect state encoding.
package pipeline_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } alu_op_t;

    typedef logic [31:0] reg_bus_t;

    // Stage bit positions inside the stall hold vector
    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;

    // A stalling stage holds itself and every stage upstream of it
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        REDIR_IDLE,
        REDIR_PEND
    } redir_state_t;

    // Furthest-downstream requester decides the hold vector
    function automatic logic [5:0] stall_encode(
        input logic r_if,
        input logic r_id,
        input logic r_ex,
        input logic r_mem
    );
        if (r_mem)
            return STALL_MEM;
        else if (r_ex)
            return STALL_EX;
        else if (r_id)
            return STALL_ID;
        else if (r_if)
            return STALL_IF;
        else
            return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Width-parameterised wrapping event counter with enable.
module perf_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count enabled cycles, wrapping naturally at 2^WIDTH
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (en)
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stall vector generation, branch/exception
// redirect with deferred branch under ID stall, stall watchdog and
// performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 1024,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_if,
    input  logic             req_id,
    input  logic             req_ex,
    input  logic             req_mem,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             exc_req,
    input  logic [31:0]      exc_vector,
    output logic [5:0]       stall,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned    RUN_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT);

    redir_state_t     state_q, state_n;
    logic [31:0]      pend_pc_q, pend_pc_n;
    logic [5:0]       stall_v;
    logic [RUN_W-1:0] run_q, run_n;

    // Stall/flush/redirect decode and redirect next-state; exception wins over all
    always_comb begin
        stall_v        = STALL_NONE;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        state_n        = state_q;
        pend_pc_n      = pend_pc_q;
        if (!rst) begin
            if (exc_req) begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = exc_vector;
                state_n        = REDIR_IDLE;
            end else begin
                stall_v = stall_encode(req_if, req_id, req_ex, req_mem);
                if (br_taken) begin
                    if (stall_v[STG_ID]) begin
                        state_n   = REDIR_PEND;
                        pend_pc_n = br_target;
                    end else begin
                        redirect_valid = 1'b1;
                        redirect_pc    = br_target;
                        state_n        = REDIR_IDLE;
                    end
                end else if (state_q == REDIR_PEND && !stall_v[STG_ID]) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = pend_pc_q;
                    state_n        = REDIR_IDLE;
                end
            end
        end
    end

    assign stall = stall_v;

    // Redirect state and deferred branch target
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REDIR_IDLE;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_n;
            pend_pc_q <= pend_pc_n;
        end
    end

    // Consecutive-stall run length, saturating at the limit
    always_comb begin
        if (stall_v == STALL_NONE)
            run_n = '0;
        else if (run_q == RUN_MAX)
            run_n = run_q;
        else
            run_n = run_q + RUN_W'(1);
    end

    // Watchdog run counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q         <= '0;
            stall_timeout <= 1'b0;
        end else begin
            run_q         <= run_n;
            stall_timeout <= stall_timeout | (run_n == RUN_MAX);
        end
    end

    perf_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .count (cycle_cnt)
    );

    perf_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_v[STG_PC]),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_pipeline_ctrl;

    localparam int unsigned LIM = 4;
    localparam int unsigned CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_if, req_id, req_ex, req_mem;
    logic          br_taken;
    logic [31:0]   br_target;
    logic          exc_req;
    logic [31:0]   exc_vector;
    logic [5:0]    stall;
    logic          flush;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          stall_timeout;
    logic [CW-1:0] cycle_cnt;
    logic [CW-1:0] stall_cnt;

    pipeline_ctrl #(.STALL_LIMIT(LIM), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_if         (req_if),
        .req_id         (req_id),
        .req_ex         (req_ex),
        .req_mem        (req_mem),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .exc_req        (exc_req),
        .exc_vector     (exc_vector),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_timeout  (stall_timeout),
        .cycle_cnt      (cycle_cnt),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    // Model state: is a branch waiting, where to, stalled run length, counts
    bit          m_pend;
    logic [31:0] m_pend_pc;
    int          m_run;
    bit          m_to;
    int          m_cyc;
    int          m_stc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    endtask

    // Number of stages held: highest requesting stage plus everything before it
    function automatic logic [5:0] exp_stall();
        int held;
        if (rst || exc_req) return 6'd0;
        held = req_mem ? 5 : req_ex ? 4 : req_id ? 3 : req_if ? 2 : 0;
        return 6'((1 << held) - 1);
    endfunction

    function automatic logic exp_rv();
        logic [5:0] s;
        s = exp_stall();
        if (rst) return 1'b0;
        if (exc_req) return 1'b1;
        return !s[2] && (br_taken || m_pend);
    endfunction

    function automatic logic [31:0] exp_rpc();
        logic [5:0] s;
        s = exp_stall();
        if (rst) return 32'd0;
        if (exc_req) return exc_vector;
        if (s[2]) return 32'd0;
        if (br_taken) return br_target;
        if (m_pend) return m_pend_pc;
        return 32'd0;
    endfunction

    // Advance the model on each edge using the inputs present at that edge
    always @(posedge clk) begin
        logic [5:0] s;
        s = exp_stall();
        if (rst) begin
            m_pend = 0; m_pend_pc = '0; m_run = 0; m_to = 0; m_cyc = 0; m_stc = 0;
        end else begin
            m_cyc = (m_cyc + 1) % (1 << CW);
            if (s[0]) m_stc = (m_stc + 1) % (1 << CW);
            if (s != 0) m_run = (m_run < LIM) ? m_run + 1 : LIM;
            else m_run = 0;
            if (m_run == LIM) m_to = 1;
            if (exc_req) m_pend = 0;
            else if (br_taken && s[2]) begin m_pend = 1; m_pend_pc = br_target; end
            else if (!s[2]) m_pend = 0;
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall",          32'(stall),          32'(exp_stall()));
            check("flush",          32'(flush),          32'(!rst && exc_req));
            check("redirect_valid", 32'(redirect_valid), 32'(exp_rv()));
            check("redirect_pc",    redirect_pc,         exp_rpc());
            check("stall_timeout",  32'(stall_timeout),  32'(m_to));
            check("cycle_cnt",      32'(cycle_cnt),      32'(m_cyc));
            check("stall_cnt",      32'(stall_cnt),      32'(m_stc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_if = 0; req_id = 0; req_ex = 0; req_mem = 0;
        br_taken = 0; br_target = '0; exc_req = 0; exc_vector = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit: got no completion, required finish");
        $fatal(1, "time limit");
    end

    initial begin
        idle_inputs();
        rst = 1;
        tick();
        tick();
        chk_en = 1;
        rst = 0;

        // Two requests together: MEM wins, then release
        req_id = 1; req_mem = 1;
        @(negedge clk); check("lit_stall_mem", 32'(stall), 32'h1f);
        tick();
        idle_inputs();
        @(negedge clk); check("lit_stall_rel", 32'(stall), 32'h0);
        tick();

        // Branch deferred under EX stall, issued on release
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            req_ex    = (c <= 3);
            br_taken  = (c == 1);
            br_target = (c == 1) ? 32'h100 : 32'h0;
            @(negedge clk);
            check("lit_defer_rv", 32'(redirect_valid), (c == 4) ? 32'd1 : 32'd0);
            if (c == 4) check("lit_defer_pc", redirect_pc, 32'h100);
            if (c == 5) check("lit_defer_pc0", redirect_pc, 32'h0);
            tick();
        end

        // Exception kills a pending branch
        do_reset();
        idle_inputs();
        req_mem = 1; br_taken = 1; br_target = 32'h100;
        tick();
        br_taken = 0; exc_req = 1; exc_vector = 32'h8;
        @(negedge clk);
        check("lit_exc_flush", 32'(flush), 32'd1);
        check("lit_exc_pc", redirect_pc, 32'h8);
        check("lit_exc_stall", 32'(stall), 32'h0);
        tick();
        idle_inputs();
        @(negedge clk); check("lit_exc_nopend", 32'(redirect_valid), 32'd0);
        tick();

        // Watchdog: four stalled edges raise the sticky flag
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            req_if = 1;
            @(negedge clk);
            check("lit_wd_rise", 32'(stall_timeout), (k >= 5) ? 32'd1 : 32'd0);
            tick();
        end
        req_if = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); check("lit_wd_hold", 32'(stall_timeout), 32'd1);
            tick();
        end
        rst = 1;
        tick();
        @(negedge clk); check("lit_wd_clr", 32'(stall_timeout), 32'd0);
        tick();

        // Counter wrap with CNT_W=4
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            req_id = (c >= 3 && c <= 7);
            tick();
        end
        req_id = 0;
        @(negedge clk);
        check("lit_cycle_cnt", 32'(cycle_cnt), 32'd4);
        check("lit_stall_cnt", 32'(stall_cnt), 32'd5);
        tick();

        // Reset during a pending branch discards it
        do_reset();
        req_id = 1; br_taken = 1; br_target = 32'h40;
        @(negedge clk); check("lit_rp_norv", 32'(redirect_valid), 32'd0);
        tick();
        rst = 1; req_id = 0; req_mem = 1; br_taken = 1; exc_req = 1; exc_vector = 32'h8;
        @(negedge clk);
        check("lit_rst_stall", 32'(stall), 32'h0);
        check("lit_rst_flush", 32'(flush), 32'd0);
        check("lit_rst_rv", 32'(redirect_valid), 32'd0);
        tick();
        idle_inputs();
        rst = 0;
        @(negedge clk);
        check("lit_rel_stall", 32'(stall), 32'h0);
        check("lit_rel_rv", 32'(redirect_valid), 32'd0);
        check("lit_rel_cyc", 32'(cycle_cnt), 32'd0);
        check("lit_rel_stc", 32'(stall_cnt), 32'd0);
        tick();
        @(negedge clk); check("lit_rel_rv2", 32'(redirect_valid), 32'd0);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 149) == 0);
            req_if     = ($urandom_range(0, 2) == 0);
            req_id     = ($urandom_range(0, 3) == 0);
            req_ex     = ($urandom_range(0, 4) == 0);
            req_mem    = ($urandom_range(0, 5) == 0);
            br_taken   = ($urandom_range(0, 3) == 0);
            br_target  = $urandom;
            exc_req    = ($urandom_range(0, 11) == 0);
            exc_vector = $urandom;
            tick();
        end

        idle_inputs();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter STALL_LIMIT, default 1024, consecutive-stall cycle count that raises stall_timeout.
REQ-002 Parameter CNT_W, default 32, performance counter width.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_if  input  1  IF stage stall request (fetch busy).
REQ-006 req_id  input  1  ID stage stall request (load-use hazard).
REQ-007 req_ex  input  1  EX stage stall request (multi-cycle op).
REQ-008 req_mem  input  1  MEM stage stall request (memory busy).
REQ-009 br_taken  input  1  ID resolved a taken branch/jump this cycle.
REQ-010 br_target  input  32  branch target, valid with br_taken.
REQ-011 exc_req  input  1  MEM stage exception.
REQ-012 exc_vector  input  32  handler address, valid with exc_req.
REQ-013 stall  output  6  stage hold vector: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
REQ-014 flush  output  1  kill all in-flight instructions in IF..MEM.
REQ-015 redirect_valid  output  1  PC takes redirect_pc this cycle.
REQ-016 redirect_pc  output  32  new PC.
REQ-017 stall_timeout  output  1  sticky watchdog flag.
REQ-018 cycle_cnt, stall_cnt  output  CNT_W each  free-running and stalled-cycle counters.

Function
REQ-019 stall SHALL be combinational from requests, highest requesting stage wins: req_mem -> 6'b011111, else req_ex -> 6'b001111, else req_id -> 6'b000111, else req_if -> 6'b000011, else 6'b000000.
REQ-020 stall[5] SHALL never be asserted.
REQ-021 exc_req SHALL force stall=0, flush=1, redirect_valid=1, redirect_pc=exc_vector in the same cycle, overriding all requests and branches, and SHALL clear any pending branch.
REQ-022 br_taken with stall[2]=0 and no exc_req SHALL give redirect_valid=1, redirect_pc=br_target in the same cycle; flush stays 0 (ID/EX bubble insertion is the pipeline registers' job).
REQ-023 br_taken with stall[2]=1 SHALL set pend_q and latch br_target into pend_pc_q at the next edge; no redirect that cycle.
REQ-024 While pend_q=1, the first cycle with stall[2]=0 and no exc_req SHALL give redirect_valid=1, redirect_pc=pend_pc_q; pend_q clears at that edge.
REQ-025 br_taken while pend_q=1 SHALL overwrite pend_pc_q (newest wins); if stall[2]=0 that cycle, br_target is issued directly and pend_q clears.
REQ-026 Redirect state machine: IDLE -> PEND on REQ-023; PEND -> IDLE on REQ-024 or exc_req; IDLE stays on REQ-022.
REQ-027 Watchdog counter run_q SHALL increment each cycle with stall!=0, saturate at STALL_LIMIT, and clear on any cycle with stall==0.
REQ-028 stall_timeout SHALL set at the edge where run_q reaches STALL_LIMIT and hold until rst.
REQ-029 cycle_cnt SHALL increment every cycle out of reset; stall_cnt SHALL increment on cycles with stall[0]=1; both wrap modulo 2^CNT_W.
REQ-030 redirect_valid SHALL be 0 and redirect_pc SHALL be 0 whenever no redirect source is active.

Reset
REQ-031 On rst: pend_q=0, pend_pc_q=0, run_q=0, stall_timeout=0, cycle_cnt=0, stall_cnt=0, state IDLE.
REQ-032 During rst, stall SHALL be 6'b000000, flush=0, redirect_valid=0 regardless of inputs.
REQ-033 rst asserted while PEND SHALL discard the pending target; no redirect after release.

Structure
REQ-034 Stall vector constants (STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM) and stage bit indices SHALL live in the shared defines header with the existing AluOp/RegBus definitions.
REQ-035 One sub-module, perf_counter (width-parameterised wrapping counter with enable), SHALL be instantiated twice.

Verification
REQ-036 req_id=1, req_mem=1 same cycle -> stall=6'b011111; release all -> stall=0 next sampled cycle.
REQ-037 req_ex=1 three cycles, br_taken=1 br_target=0x100 in cycle 1 -> no redirect cycles 1-3; cycle 4 (req_ex=0) redirect_valid=1, redirect_pc=0x100; cycle 5 redirect_valid=0.
REQ-038 Pending branch 0x100 under req_mem, then exc_req exc_vector=0x8 -> flush=1, redirect_pc=0x8, stall=0; later stall release gives no redirect to 0x100.
REQ-039 STALL_LIMIT=4, req_if held 6 cycles -> stall_timeout rises after 4th stalled edge, stays 1 after req_if drops, clears only on rst.
REQ-040 CNT_W=4, 20 cycles with req_id on cycles 3-7 -> cycle_cnt=4 (20 mod 16), stall_cnt=5.
REQ-041 rst asserted mid-PEND with br_target=0x40 -> after release, stall=0, redirect_valid stays 0, counters read 0.
